// File: rtl/ppu_pkg.sv
// ppu_pkg: PPU pixel-SRAM constants and reader state type.
//   PPU_ADDR_W  word address width of the 1024x24 pixel SRAM
//   PPU_DATA_W  pixel word width
//   rd_state_t  sram_line_reader FSM states
package ppu_pkg;
  localparam int PPU_ADDR_W = 10;
  localparam int PPU_DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;
endpackage

// File: rtl/ppu_sync_fifo.sv
// ppu_sync_fifo: single-clock FIFO with first-word-fall-through head.
//   clk, rst         clock, synchronous active-high reset (empties FIFO)
//   push, push_data  write one entry (ignored when full)
//   pop              remove head entry (ignored when empty)
//   head             current head entry, meaningful while !empty
//   empty, count     occupancy status
module ppu_sync_fifo
  import ppu_pkg::*;
#(
  parameter int W     = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/sram_line_reader.sv
// sram_line_reader: port-B read master streaming a run of consecutive SRAM
// words to a valid/ready pixel consumer.
//   sram_clk, sram_rst           clock, synchronous active-high reset
//   start, base_addr, length     run command (accepted only when idle)
//   busy, done                   run in progress / 1-cycle completion pulse
//   SRAM_CS_B_N, SRAM_WE_B_N,
//   SRAM_ADDR_B, SRAM_RDATA_B    SRAM port B (read only, 1-cycle latency)
//   pix_valid, pix_data,
//   pix_last, pix_ready          output stream
// Optional: define SRAM_LINE_READER_STALL_CNT_EN to add stall_cnt[15:0],
// a saturating count of busy cycles where the consumer held off a valid word.
module sram_line_reader
  import ppu_pkg::*;
#(
  parameter int ADDR_W     = PPU_ADDR_W,
  parameter int DATA_W     = PPU_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sram_clk,
  input  logic              sram_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              SRAM_CS_B_N,
  output logic              SRAM_WE_B_N,
  output logic [ADDR_W-1:0] SRAM_ADDR_B,
  input  logic [DATA_W-1:0] SRAM_RDATA_B,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_last,
  input  logic              pix_ready
`ifdef SRAM_LINE_READER_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH);

  rd_state_t         state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   len_r, issued;
  logic              rd_pending, rd_last;
  logic              issue, last_issue, accept, pop, done_nx;
  logic [CW:0]       fifo_count, credit_used;
  logic [DATA_W:0]   head;
  logic              fifo_empty;

  // Words already buffered plus the one still in the SRAM read pipe must
  // leave room for the word about to be requested.
  assign credit_used = fifo_count + (CW+1)'(rd_pending);
  assign last_issue  = (issued == len_r - (ADDR_W+1)'(1));

  always_ff @(posedge sram_clk) begin
    if (sram_rst) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    accept   = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept = 1'b1;
        if (length != '0) state_nx = READ;
        else              done_nx  = 1'b1;
      end
      READ: begin
        issue = (issued < len_r) && (credit_used < (CW+1)'(FIFO_DEPTH));
        if (issue && last_issue) state_nx = DRAIN;
      end
      DRAIN: if (pop && pix_last) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sram_clk) begin
    if (sram_rst) begin
      addr       <= '0;
      len_r      <= '0;
      issued     <= '0;
      rd_pending <= 1'b0;
      rd_last    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= done_nx;
      rd_pending <= issue;
      rd_last    <= issue && last_issue;
      if (accept) begin
        addr   <= base_addr;
        len_r  <= length;
        issued <= '0;
      end else if (issue) begin
        addr   <= addr + 1'b1;   // wraps mod 2^ADDR_W
        issued <= issued + 1'b1;
      end
    end
  end

  assign busy        = (state != IDLE);
  assign SRAM_CS_B_N = ~issue;
  assign SRAM_WE_B_N = 1'b1;
  assign SRAM_ADDR_B = addr;

  // The last flag travels with its data word so pix_last needs no counter
  // on the output side.
  ppu_sync_fifo #(.W(DATA_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (sram_clk),
    .rst       (sram_rst),
    .push      (rd_pending),
    .push_data ({rd_last, SRAM_RDATA_B}),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pix_valid = ~fifo_empty;
  assign pix_data  = head[DATA_W-1:0];
  assign pix_last  = pix_valid & head[DATA_W];
  assign pop       = pix_valid & pix_ready;

`ifdef SRAM_LINE_READER_STALL_CNT_EN
  always_ff @(posedge sram_clk) begin
    if (sram_rst)                                   stall_cnt <= '0;
    else if (accept)                                stall_cnt <= '0;
    else if (busy && pix_valid && !pix_ready &&
             stall_cnt != 16'hFFFF)                 stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_sram_line_reader.sv
// tb_sram_line_reader: randomized/directed bench for sram_line_reader with a
// registered-read SRAM model and a queue-based expected-stream model.
module tb_sram_line_reader;
  logic        clk = 1'b0;
  logic        sram_rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic        busy, done, cs_n, we_n;
  logic [9:0]  addr_b;
  logic [23:0] rdata;
  logic        pix_valid, pix_last, pix_ready;
  logic [23:0] pix_data;
`ifdef SRAM_LINE_READER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  sram_line_reader dut (
    .sram_clk     (clk),
    .sram_rst     (sram_rst),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .SRAM_CS_B_N  (cs_n),
    .SRAM_WE_B_N  (we_n),
    .SRAM_ADDR_B  (addr_b),
    .SRAM_RDATA_B (rdata),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_last     (pix_last),
    .pix_ready    (pix_ready)
`ifdef SRAM_LINE_READER_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  // Pixel SRAM: registered read, data valid the cycle after CS_N low.
  logic [23:0] mem [1024];
  always @(posedge clk) if (!cs_n) rdata <= mem[addr_b];

  int          n_chk = 0, n_pass = 0;
  int          exp_addr[$];
  logic [23:0] exp_data[$];
  int          n_iss, n_pop, n_done, stalls;
  int          first_k, last_k, done_k;
  logic        prev_hold;
  logic [23:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: sample after the edge, choose pix_ready, score the cycle.
  task automatic step(input logic rdy, input int k);
    @(posedge clk); #1;
    start     = 1'b0;
    pix_ready = rdy;
    chk("we_n", we_n, 1);
    if (prev_hold) begin
      chk("hold_valid", pix_valid, 1);
      chk("hold_data", pix_data, prev_data);
    end
    if (!cs_n) begin
      n_iss++;
      if (exp_addr.size() == 0) chk("extra_issue", exp_addr.size(), 1);
      else chk("rd_addr", addr_b, exp_addr.pop_front());
      chk("credit", (n_iss - n_pop) <= 4, 1);
    end
    if (done) begin n_done++; done_k = k; end
    if (pix_valid && first_k < 0) first_k = k;
    if (busy && pix_valid && !pix_ready) stalls++;
    if (pix_valid && pix_ready) begin
      if (exp_data.size() == 0) chk("extra_word", exp_data.size(), 1);
      else begin
        chk("last", pix_last, exp_data.size() == 1);
        chk("data", pix_data, exp_data.pop_front());
        if (exp_data.size() == 0) last_k = k;
      end
      n_pop++;
    end
    prev_hold = pix_valid && !pix_ready;
    prev_data = pix_data;
  endtask

  // mode 0: always ready, 1: 10-cycle stall after 5 words, 2: random ready.
  task automatic run(input int base, input int len, input int mode, input int rst_at);
    int   k, stall_left;
    logic rdy;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back((base + i) % 1024);
      exp_data.push_back(mem[(base + i) % 1024]);
    end
    n_iss = 0; n_pop = 0; n_done = 0; stalls = 0;
    first_k = -1; last_k = -1; done_k = -1; prev_hold = 1'b0;
    base_addr = 10'(base); length = 11'(len); start = 1'b1;
    k = 0; stall_left = 10;
    while (k < 5000) begin
      k++;
      rdy = 1'b1;
      if (mode == 1 && n_pop >= 5 && stall_left > 0) begin rdy = 1'b0; stall_left--; end
      if (mode == 2) rdy = ($urandom_range(0, 3) != 0);
      if (mode == 1 && k == 4) begin start = 1'b1; base_addr = 10'd7; length = 11'd3; end
      step(rdy, k);
      if (mode == 1 && !rdy && stall_left == 0) begin
        chk("stall_full", n_iss - n_pop, 4);
        chk("stall_cs", cs_n, 1);
      end
      if (rst_at >= 0 && n_pop == rst_at) begin
        sram_rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", cs_n, 1);
        chk("rst_addr", addr_b, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_last", pix_last, 0);
        sram_rst = 1'b0;
        prev_hold = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        for (int j = 0; j < 3; j++) step(1'b1, 0);
        chk("rst_no_done", n_done, 0);
        chk("rst_idle_valid", pix_valid, 0);
        return;
      end
      if (n_done > 0) break;
    end
    step(1'b1, k + 1);
    step(1'b1, k + 2);
    chk("done_once", n_done, 1);
    chk("all_words", exp_data.size(), 0);
    chk("all_issued", n_iss, len);
    chk("idle_busy", busy, 0);
    chk("done_after_last", done_k, last_k + 1);
    if (mode == 0) begin
      chk("first_latency", first_k, 3);
      chk("throughput", last_k, 3 + len - 1);
    end
`ifdef SRAM_LINE_READER_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stalls);
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 24'(i * 3);
    sram_rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; pix_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cs", cs_n, 1);
    chk("reset_we", we_n, 1);
    chk("reset_addr", addr_b, 0);
    chk("reset_valid", pix_valid, 0);
    chk("reset_last", pix_last, 0);
    sram_rst = 1'b0;
    @(posedge clk); #1;

    run(5, 8, 0, -1);       // words 15..36
    run(1022, 4, 0, -1);    // address wrap
    run(100, 16, 2, -1);    // random backpressure
    run(300, 16, 1, -1);    // long stall, plus ignored start while busy

    // Zero-length command
    prev_hold = 1'b0; n_iss = 0; n_done = 0;
    base_addr = 10'd3; length = 11'd0; start = 1'b1;
    step(1'b1, 1);
    chk("len0_done", done, 1);
    chk("len0_cs", cs_n, 1);
    chk("len0_valid", pix_valid, 0);
    chk("len0_busy", busy, 0);
    step(1'b1, 2);
    chk("len0_done_pulse", done, 0);
    chk("len0_no_issue", n_iss, 0);

    run(200, 10, 0, 3);     // reset mid-run
    run(40, 6, 0, -1);      // clean run after reset
    run(0, 1024, 2, -1);    // full SRAM, random ready

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
